traffic_phase_sequencer: RTL



---
 rtl/traffic_pkg.sv | 39 +++
 rtl/phase_timer.sv | 36 +++
 rtl/traffic_phase_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings and default timings for the two-road intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } phase_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int unsigned DEF_GREEN_NS_SEC = 10;
    localparam int unsigned DEF_GREEN_EW_SEC = 8;
    localparam int unsigned DEF_YELLOW_SEC   = 3;
    localparam int unsigned DEF_ALL_RED_SEC  = 1;
    localparam int unsigned DEF_CNT_W        = 6;

    function automatic logic [2:0] ns_lamp(input phase_t p);
        case (p)
            NS_GREEN:  ns_lamp = GREEN;
            NS_YELLOW: ns_lamp = YELLOW;
            default:   ns_lamp = RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_t p);
        case (p)
            EW_GREEN:  ew_lamp = GREEN;
            EW_YELLOW: ew_lamp = YELLOW;
            default:   ew_lamp = RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase seconds counter: gates ticks against the divider restart, saturates,
// and flags phase completion / minimum elapsed.
module phase_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sec_tick,
    input  logic             restart,
    input  logic [CNT_W-1:0] dur,
    output logic             done,
    output logic             elapsed_min
);

    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] last;
    logic             valid_tick;

    assign valid_tick  = sec_tick & ~restart;
    assign last        = dur - CNT_W'(1);
    assign done        = valid_tick && (sec_cnt == last);
    assign elapsed_min = valid_tick && (sec_cnt >= last);

    // Clearing on restart (the cycle after a phase change) is equivalent to clearing
    // on the change itself, since no tick can be counted in that cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sec_cnt <= '0;
        end else if (restart) begin
            sec_cnt <= '0;
        end else if (valid_tick && (sec_cnt != '1)) begin
            sec_cnt <= sec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase FSM: sequences NS/EW lights on one-second ticks, re-aligns the
// divider at every phase change and serves latched pedestrian requests on EW green.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_NS_SEC = DEF_GREEN_NS_SEC,
    parameter int unsigned GREEN_EW_SEC = DEF_GREEN_EW_SEC,
    parameter int unsigned YELLOW_SEC   = DEF_YELLOW_SEC,
    parameter int unsigned ALL_RED_SEC  = DEF_ALL_RED_SEC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sec_tick,
    input  logic       ew_sensor,
    input  logic       ped_req,
    output logic       divider_reset,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    phase_t           state;
    phase_t           nxt;
    logic             ped_pending;
    logic             done;
    logic             elapsed_min;
    logic [CNT_W-1:0] dur;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .sec_tick    (sec_tick),
        .restart     (divider_reset),
        .dur         (dur),
        .done        (done),
        .elapsed_min (elapsed_min)
    );

    always_comb begin
        dur = CNT_W'(ALL_RED_SEC);
        case (state)
            NS_GREEN:             dur = CNT_W'(GREEN_NS_SEC);
            NS_YELLOW, EW_YELLOW: dur = CNT_W'(YELLOW_SEC);
            EW_GREEN:             dur = CNT_W'(GREEN_EW_SEC);
            default:              dur = CNT_W'(ALL_RED_SEC);
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            NS_GREEN:  if (elapsed_min && (ew_sensor || ped_pending)) nxt = NS_YELLOW;
            NS_YELLOW: if (done) nxt = RED_A;
            RED_A:     if (done) nxt = EW_GREEN;
            EW_GREEN:  if (done) nxt = EW_YELLOW;
            EW_YELLOW: if (done) nxt = RED_B;
            RED_B:     if (done) nxt = NS_GREEN;
            default:   nxt = RED_B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RED_B;
            ped_pending   <= 1'b0;
            divider_reset <= 1'b1;
            ns_light      <= RED;
            ew_light      <= RED;
            walk          <= 1'b0;
        end else begin
            state         <= nxt;
            divider_reset <= (nxt != state);
            ns_light      <= ns_lamp(nxt);
            ew_light      <= ew_lamp(nxt);
            walk          <= (nxt == EW_GREEN);
            // A request arriving on the EW green entry cycle is kept for the next round.
            if (ped_req) begin
                ped_pending <= 1'b1;
            end else if ((nxt == EW_GREEN) && (state != EW_GREEN)) begin
                ped_pending <= 1'b0;
            end
        end
    end

    assign phase = state;

endmodule
